alu_wb_stage: RTL

//  Writeback/commit stage directly downstream of ALU_LL. Captures G, ZCNVFlags and op tag
//  per issued operation into a 2-entry skid buffer with valid/ready on both sides.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_skid_buf.sv | 74 +++++++
 rtl/alu_wb_stage.sv | 72 +++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU writeback stage: op codes, flag bit positions,
// default widths and the packed entry width helper.
package alu_pkg;

  localparam int DW_DEF    = 32;
  localparam int RW_DEF    = 5;
  localparam int CNT_W_DEF = 16;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1100;
  localparam logic [3:0] OP_AND = 4'b1110;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // Entry layout: {g, zcnv, gsel, rd, setf}
  localparam int ENTRY_W = DW_DEF + 4 + 4 + RW_DEF + 1;

  function automatic int entry_width(input int dw, input int rw);
    return dw + 4 + 4 + rw + 1;
  endfunction

  // Only ADD/SUB produce a meaningful signed-overflow V flag.
  function automatic logic is_arith(input logic [3:0] gsel);
    return (gsel == OP_ADD) || (gsel == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready buffer. The head entry is held in a register so
// the output is glitch-free, appears one cycle after the push, and keeps the
// last popped value while the buffer is empty.
module alu_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [W-1:0] head_q;

  logic         push;
  logic         pop;
  logic [1:0]   count_nxt;
  logic         rd_ptr_nxt;
  logic [W-1:0] head_nxt;

  // Ready and valid come straight from registered occupancy.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = head_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next occupancy, read pointer and head entry. When the new head slot is the
  // one being written this cycle, forward the incoming data directly.
  always_comb begin
    count_nxt  = count;
    rd_ptr_nxt = rd_ptr ^ pop;
    head_nxt   = head_q;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
    if (count_nxt != 2'd0) begin
      if (push && (rd_ptr_nxt == wr_ptr)) head_nxt = in_data;
      else                                 head_nxt = mem[rd_ptr_nxt];
    end
  end

  // Storage slots; contents are irrelevant until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Pointer, occupancy and head register; reset discards in-flight entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      head_q <= '0;
    end else begin
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      head_q <= head_nxt;
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// Writeback/commit stage behind the ALU: buffers results in a 2-entry skid
// buffer, commits them in order to the register file, and on commit updates
// the architectural ZCNV register and a saturating signed-overflow counter.
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int RW    = RW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_g,
  input  logic [3:0]       in_zcnv,
  input  logic [3:0]       in_gsel,
  input  logic [RW-1:0]    in_rd,
  input  logic             in_setf,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [DW-1:0]    wb_data,
  output logic [RW-1:0]    wb_rd,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             clr_stats
);

  localparam int EW = entry_width(DW, RW);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [EW-1:0] in_entry;
  logic [EW-1:0] head_entry;
  logic [3:0]    head_zcnv;
  logic [3:0]    head_gsel;
  logic          head_setf;
  logic          pop;
  logic          ovf_inc;

  assign in_entry = {in_g, in_zcnv, in_gsel, in_rd, in_setf};
  assign {wb_data, head_zcnv, head_gsel, wb_rd, head_setf} = head_entry;

  alu_skid_buf #(.W(EW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (wb_valid),
    .out_ready (wb_ready),
    .out_data  (head_entry)
  );

  assign pop = wb_valid & wb_ready;

  // Logical ops can leave V set as an ALU artefact; only ADD/SUB count.
  assign ovf_inc = pop & head_setf & head_zcnv[FLAG_V] & is_arith(head_gsel);

  // Architectural flags follow the committing entry when it sets flags.
  always_ff @(posedge clk) begin
    if (rst)                  flags_q <= 4'b0000;
    else if (pop & head_setf) flags_q <= head_zcnv;
  end

  // Overflow event counter: clear wins over increment, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst)                                ovf_cnt <= '0;
    else if (clr_stats)                     ovf_cnt <= '0;
    else if (ovf_inc && ovf_cnt != CNT_MAX) ovf_cnt <= ovf_cnt + 1'b1;
  end

endmodule
